mdio_master_cmd: RTL and testbench

- Parametrised MDIO/SMI management master: accepts one command per valid/ready handshake, serialises a full Clause 22 or Clause 45 management frame on MDC/MDIO, returns read data or completion plus an error flag.
- Sits between the PHY configuration/status controller and the PHY management pins.
- New over the previous generation: programmable MDC divider and preamble length, Clause 45 frames, no-PHY (turnaround) error detection, command/response handshake.

---
 rtl/mdio_master_cmd.sv | 203 ++++++++++++++++++++
 tb/tb_mdio_master_cmd.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master_cmd.sv
// mdio_master_cmd: MDIO/SMI management master with a command/response handshake.
// Serialises one Clause 22 or Clause 45 frame per accepted command on mdc/mdio
// and returns read data (or completion) with an error flag.
//
// Ports:
//   clk, rst_n                      system clock, synchronous active-low reset
//   cmd_valid / cmd_ready           command handshake (ready = idle)
//   cmd_c45, cmd_op, cmd_phyad,
//   cmd_regad, cmd_data             command fields, latched on accept
//   rsp_valid, rsp_data, rsp_err    one-cycle completion pulse; data/err hold
//   busy                            frame in progress (~cmd_ready)
//   mdc, mdio_o, mdio_oe, mdio_i    management pins (tri-state buffer external)
module mdio_master_cmd #(
  parameter int unsigned CLK_DIV     = 250,
  parameter int unsigned PRE_LEN     = 32,
  parameter int unsigned SUPPORT_C45 = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_c45,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_phyad,
  input  logic [4:0]  cmd_regad,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int unsigned N_BITS = PRE_LEN + 32;
  localparam int unsigned DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W  = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_FRAME = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_c45;
  logic [1:0]         r_op;
  logic [4:0]         r_phyad;
  logic [4:0]         r_regad;
  logic [15:0]        r_data;
  logic [63:0]        r_sh;
  logic [DIV_W-1:0]   r_div;
  logic [BIT_W-1:0]   r_bit;
  logic [15:0]        r_rd_sh;
  logic               r_ta;
  logic               r_cmd_ready;
  logic               r_busy;
  logic               r_rsp_valid;
  logic [15:0]        r_rsp_data;
  logic               r_rsp_err;
  logic               r_mdc;
  logic               r_mdio_o;
  logic               r_mdio_oe;

  logic               w_c45_cmd;
  logic               w_illegal;
  logic               w_read;
  logic [31:0]        w_frame32;
  logic [63:0]        w_frame64;
  logic [63:0]        w_sh_next;
  logic               w_div_end;
  logic               w_last;

  // Clause 45 requests collapse to Clause 22 when C45 support is compiled out.
  assign w_c45_cmd = (SUPPORT_C45 != 0) && cmd_c45;

  assign w_illegal = !r_c45 && ((r_op == 2'b00) || (r_op == 2'b11));
  assign w_read    = r_c45 ? r_op[1] : (r_op == 2'b10);

  // Read frames carry ones after REGAD so mdio_o idles high while released.
  assign w_frame32 = {1'b0, !r_c45, r_op, r_phyad, r_regad,
                      w_read ? 18'h3FFFF : {2'b10, r_data}};

  // Top PRE_LEN bits are preamble ones, followed by the 32-bit frame body.
  assign w_frame64 = {32'hFFFF_FFFF, w_frame32} << (32 - PRE_LEN);
  assign w_sh_next = r_sh << 1;

  assign w_div_end = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_last    = (r_bit == BIT_W'(N_BITS - 1));

  // Control FSM, MDC divider, shifter and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_c45       <= 1'b0;
      r_op        <= 2'b00;
      r_phyad     <= 5'd0;
      r_regad     <= 5'd0;
      r_data      <= 16'd0;
      r_sh        <= 64'd0;
      r_div       <= '0;
      r_bit       <= '0;
      r_rd_sh     <= 16'd0;
      r_ta        <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 16'd0;
      r_rsp_err   <= 1'b0;
      r_mdc       <= 1'b0;
      r_mdio_o    <= 1'b1;
      r_mdio_oe   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        // RESP is also idle for acceptance purposes: ready is already high.
        S_IDLE, S_RESP: begin
          if (cmd_valid) begin
            r_c45       <= w_c45_cmd;
            r_op        <= cmd_op;
            r_phyad     <= cmd_phyad;
            r_regad     <= cmd_regad;
            r_data      <= cmd_data;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_START;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_START: begin
          if (w_illegal) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= 16'd0;
            r_rsp_err   <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_RESP;
          end else begin
            r_sh      <= w_frame64;
            r_mdio_o  <= w_frame64[63];
            r_mdio_oe <= 1'b1;
            r_mdc     <= 1'b0;
            r_div     <= '0;
            r_bit     <= '0;
            r_state   <= S_FRAME;
          end
        end

        S_FRAME: begin
          if (!w_div_end) begin
            r_div <= r_div + DIV_W'(1);
          end else begin
            r_div <= '0;
            if (!r_mdc) begin
              // Rising MDC: sample the PHY-driven bit.
              r_mdc <= 1'b1;
              if (r_bit == BIT_W'(PRE_LEN + 15)) begin
                r_ta <= mdio_i;
              end
              if (r_bit >= BIT_W'(PRE_LEN + 16)) begin
                r_rd_sh <= {r_rd_sh[14:0], mdio_i};
              end
            end else if (w_last) begin
              r_mdc       <= 1'b0;
              r_mdio_oe   <= 1'b0;
              r_mdio_o    <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= w_read ? r_rd_sh : 16'd0;
              r_rsp_err   <= w_read & r_ta;
              r_cmd_ready <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= S_RESP;
            end else begin
              // Falling MDC: advance to the next bit; reads release at TA.
              r_mdc     <= 1'b0;
              r_bit     <= r_bit + BIT_W'(1);
              r_sh      <= w_sh_next;
              r_mdio_o  <= w_sh_next[63];
              r_mdio_oe <= !(w_read && (r_bit >= BIT_W'(PRE_LEN + 13)));
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign mdc       = r_mdc;
  assign mdio_o    = r_mdio_o;
  assign mdio_oe   = r_mdio_oe;

endmodule

// File: tb/tb_mdio_master_cmd.sv
// Self-checking bench for mdio_master_cmd: two instances (CLK_DIV=4/PRE_LEN=32
// with C45, and CLK_DIV=2/PRE_LEN=0 without C45), directed plus random commands
// checked cycle by cycle against a bit-list frame model and a simple PHY model.
module tb_mdio_master_cmd;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [2];
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic        cmd_c45   [2];
  logic [1:0]  cmd_op    [2];
  logic [4:0]  cmd_phyad [2];
  logic [4:0]  cmd_regad [2];
  logic [15:0] cmd_data  [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_data  [2];
  logic        rsp_err   [2];
  logic        busy      [2];
  logic        mdc       [2];
  logic        mdio_o    [2];
  logic        mdio_oe   [2];
  logic        mdio_i    [2];

  int checks = 0;
  int errors = 0;

  mdio_master_cmd #(.CLK_DIV(4), .PRE_LEN(32), .SUPPORT_C45(1)) u_a (
    .clk(clk), .rst_n(rst_n[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_c45(cmd_c45[0]), .cmd_op(cmd_op[0]), .cmd_phyad(cmd_phyad[0]),
    .cmd_regad(cmd_regad[0]), .cmd_data(cmd_data[0]), .rsp_valid(rsp_valid[0]),
    .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]), .busy(busy[0]), .mdc(mdc[0]),
    .mdio_o(mdio_o[0]), .mdio_oe(mdio_oe[0]), .mdio_i(mdio_i[0]));

  mdio_master_cmd #(.CLK_DIV(2), .PRE_LEN(0), .SUPPORT_C45(0)) u_b (
    .clk(clk), .rst_n(rst_n[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_c45(cmd_c45[1]), .cmd_op(cmd_op[1]), .cmd_phyad(cmd_phyad[1]),
    .cmd_regad(cmd_regad[1]), .cmd_data(cmd_data[1]), .rsp_valid(rsp_valid[1]),
    .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]), .busy(busy[1]), .mdc(mdc[1]),
    .mdio_o(mdio_o[1]), .mdio_oe(mdio_oe[1]), .mdio_i(mdio_i[1]));

  function automatic int cdiv(input int u);
    return (u == 0) ? 4 : 2;
  endfunction

  function automatic int plen(input int u);
    return (u == 0) ? 32 : 0;
  endfunction

  function automatic int sc45(input int u);
    return (u == 0) ? 1 : 0;
  endfunction

  // {mdc, oe, oe&o, rsp_valid, cmd_ready, busy}
  function automatic logic [5:0] obs_vec(input int u);
    return {mdc[u], mdio_oe[u], mdio_oe[u] & mdio_o[u], rsp_valid[u], cmd_ready[u], busy[u]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input int u, input string tag);
    chk({tag, " vec"}, 32'(obs_vec(u)), 32'(6'b000010));
    chk({tag, " mdio_o"}, 32'(mdio_o[u]), 32'd1);
    chk({tag, " rsp"}, {15'd0, rsp_data[u], rsp_err[u]}, 32'd0);
  endtask

  // Issue one command and check every cycle until the response (or abort).
  task automatic run_cmd(input int u, input bit c45, input logic [1:0] op,
                         input logic [4:0] phy, input logic [4:0] rg,
                         input logic [15:0] dat, input logic [15:0] pdat,
                         input bit present, input bit pre, input bit hold,
                         input int abort_at, output bit aborted);
    int d, p, n, last, k, h;
    bit ec45, ill, rd, eoe, eo;
    bit fb[$];
    logic [15:0] edata;
    logic eerr;
    d = cdiv(u); p = plen(u); n = p + 32;
    ec45 = (sc45(u) != 0) && c45;
    ill  = !ec45 && (op == 2'b00 || op == 2'b11);
    rd   = ec45 ? (op == 2'b10 || op == 2'b11) : (op == 2'b10);
    for (int i = 0; i < p; i++) fb.push_back(1'b1);
    fb.push_back(1'b0);
    fb.push_back(!ec45);
    for (int i = 1; i >= 0; i--) fb.push_back(op[i]);
    for (int i = 4; i >= 0; i--) fb.push_back(phy[i]);
    for (int i = 4; i >= 0; i--) fb.push_back(rg[i]);
    if (rd) begin
      for (int i = 0; i < 18; i++) fb.push_back(1'b1);
    end else begin
      fb.push_back(1'b1);
      fb.push_back(1'b0);
      for (int i = 15; i >= 0; i--) fb.push_back(dat[i]);
    end
    edata = (!ill && rd) ? (present ? pdat : 16'hFFFF) : 16'h0000;
    eerr  = ill || (rd && !present);
    aborted = 1'b0;

    if (!pre) @(negedge clk);
    cmd_c45[u] = c45; cmd_op[u] = op; cmd_phyad[u] = phy;
    cmd_regad[u] = rg; cmd_data[u] = dat; cmd_valid[u] = 1'b1;
    mdio_i[u] = 1'b1;
    chk($sformatf("u%0d ready_before_accept", u), 32'(cmd_ready[u]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("u%0d cycle0", u), 32'(obs_vec(u)), 32'(6'b000001));
    if (!hold) begin
      cmd_valid[u] = 1'b0;
      cmd_c45[u] = 1'($urandom); cmd_op[u] = 2'($urandom);
      cmd_phyad[u] = 5'($urandom); cmd_regad[u] = 5'($urandom);
      cmd_data[u] = 16'($urandom);
    end
    last = ill ? 1 : 2 * n * d + 1;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == abort_at) begin
        aborted = 1'b1;
        return;
      end
      if (c < last) begin
        k = (c - 1) / (2 * d);
        h = ((c - 1) / d) % 2;
        eoe = !(rd && k >= p + 14);
        eo  = fb[k];
        chk($sformatf("u%0d frame c%0d bit%0d", u, c, k), 32'(obs_vec(u)),
            32'({1'(h), eoe, eoe & eo, 3'b001}));
        if (present && rd && k >= p + 15)
          mdio_i[u] = (k == p + 15) ? 1'b0 : pdat[15 - (k - p - 16)];
        else
          mdio_i[u] = 1'b1;
      end else begin
        chk($sformatf("u%0d resp c%0d vec", u, c), 32'(obs_vec(u)), 32'(6'b000110));
        chk($sformatf("u%0d resp mdio_o", u), 32'(mdio_o[u]), 32'd1);
        chk($sformatf("u%0d resp data", u), 32'(rsp_data[u]), 32'(edata));
        chk($sformatf("u%0d resp err", u), 32'(rsp_err[u]), 32'(eerr));
        mdio_i[u] = 1'b1;
      end
    end
    if (!hold) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("u%0d rsp hold", u), {14'd0, rsp_valid[u], rsp_data[u], rsp_err[u]},
          {14'd0, 1'b0, edata, eerr});
    end
  endtask

  initial begin
    bit ab;
    logic [1:0] rop;
    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 1'b0; cmd_valid[u] = 1'b0; cmd_c45[u] = 1'b0; cmd_op[u] = 2'b00;
      cmd_phyad[u] = 5'd0; cmd_regad[u] = 5'd0; cmd_data[u] = 16'd0; mdio_i[u] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state(0, "reset u0");
    chk_reset_state(1, "reset u1");
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // C22 write, C22 read with PHY, C22 read with no PHY.
    run_cmd(0, 1'b0, 2'b01, 5'd1, 5'd0, 16'h1140, 16'h0000, 1'b0, 1'b0, 1'b0, 0, ab);
    run_cmd(0, 1'b0, 2'b10, 5'd1, 5'd2, 16'h0000, 16'h796D, 1'b1, 1'b0, 1'b0, 0, ab);
    run_cmd(0, 1'b0, 2'b10, 5'd1, 5'd2, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 0, ab);
    // C45 address then C45 read.
    run_cmd(0, 1'b1, 2'b00, 5'd1, 5'd1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 0, ab);
    run_cmd(0, 1'b1, 2'b11, 5'd1, 5'd1, 16'h0000, 16'h0020, 1'b1, 1'b0, 1'b0, 0, ab);

    // No preamble, fast divider; then illegal ops (C45 compiled out on u1).
    run_cmd(1, 1'b0, 2'b01, 5'd3, 5'd4, 16'hA5C3, 16'h0000, 1'b0, 1'b0, 1'b0, 0, ab);
    run_cmd(1, 1'b0, 2'b00, 5'd3, 5'd4, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 0, ab);
    run_cmd(1, 1'b1, 2'b11, 5'd3, 5'd4, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 0, ab);
    run_cmd(1, 1'b0, 2'b10, 5'd9, 5'd17, 16'h0000, 16'h5AF0, 1'b1, 1'b0, 1'b0, 0, ab);

    // Random commands.
    for (int i = 0; i < 4; i++) begin
      rop = 2'($urandom);
      run_cmd(0, 1'($urandom), rop, 5'($urandom), 5'($urandom), 16'($urandom),
              16'($urandom), 1'($urandom), 1'b0, 1'b0, 0, ab);
    end
    for (int i = 0; i < 14; i++) begin
      rop = 2'($urandom);
      run_cmd(1, 1'($urandom), rop, 5'($urandom), 5'($urandom), 16'($urandom),
              16'($urandom), 1'($urandom), 1'b0, 1'b0, 0, ab);
    end

    // Back-to-back with cmd_valid held high, then reset mid second frame.
    run_cmd(0, 1'b0, 2'b10, 5'd5, 5'd6, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 1'b1, 0, ab);
    run_cmd(0, 1'b0, 2'b01, 5'd7, 5'd8, 16'h3C3C, 16'h0000, 1'b0, 1'b1, 1'b0, 150, ab);
    chk("abort reached", 32'(ab), 32'd1);
    rst_n[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_state(0, "midframe reset");
    rst_n[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("post reset idle c%0d", c), 32'(obs_vec(0)), 32'(6'b000010));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
